// File: rtl/sm4_key_expand_if.sv
// Round-key stream between the SM4 key schedule and the round datapath.
// The key schedule drives the master side; the consumer drives rk_ready.
interface sm4_key_expand_if;
    logic        rk_valid;
    logic        rk_ready;
    logic [31:0] rk_data;
    logic        rk_last;

    modport master (
        output rk_valid,
        output rk_data,
        output rk_last,
        input  rk_ready
    );

    modport slave (
        input  rk_valid,
        input  rk_data,
        input  rk_last,
        output rk_ready
    );
endinterface

// File: rtl/sm4_key_expand.sv
// SM4 key schedule: expands a 128-bit master key into rk0..rk31 (one per clock),
// keeps them in a 32-entry register file, streams them and serves a registered read port.
module sm4_key_expand #(
    parameter int STREAM_EN = 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [127:0]     mk,
    input  logic             mode,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             keys_valid,
    sm4_key_expand_if.master rk_if,
    input  logic [4:0]       rd_idx,
    output logic [31:0]      rd_key
);
    localparam logic [127:0] FK = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

    localparam logic [2047:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    typedef enum logic [1:0] {IDLE, LOAD, EXPAND, STREAM} state_t;

    state_t        state_reg, state_next;
    logic [4:0]    cnt_reg;
    logic [127:0]  mk_reg;
    logic          mode_reg;
    logic [31:0]   k_reg [4];
    logic [31:0]   rf [32];
    logic          done_reg;
    logic          keys_valid_reg;
    logic [31:0]   rd_key_reg;

    logic          accept;
    logic          handshake;
    logic          expand_last;
    logic [7:0]    ck_base;
    logic [31:0]   ck;
    logic [31:0]   tau_in;
    logic [31:0]   rk_new;

    function automatic logic [7:0] sbox(input logic [7:0] a);
        return SBOX[(255 - int'(a)) * 8 +: 8];
    endfunction

    // Key-schedule transform: byte-wise S-box followed by L'.
    function automatic logic [31:0] t_prime(input logic [31:0] x);
        logic [31:0] b;
        b = {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
        return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    endfunction

    // CK_i bytes are 28*i + 7*j, so only the base byte needs a multiply.
    always_comb begin
        ck_base = 8'(cnt_reg) * 8'd28;
        ck      = {ck_base, ck_base + 8'd7, ck_base + 8'd14, ck_base + 8'd21};
        tau_in  = k_reg[1] ^ k_reg[2] ^ k_reg[3] ^ ck;
        rk_new  = k_reg[0] ^ t_prime(tau_in);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // The done cycle counts as not-yet-idle for start, so a start there is dropped.
    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        handshake   = 1'b0;
        expand_last = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !done_reg) begin
                    accept     = 1'b1;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                state_next = EXPAND;
            end
            EXPAND: begin
                if (cnt_reg == 5'd31) begin
                    expand_last = 1'b1;
                    state_next  = (STREAM_EN != 0) ? STREAM : IDLE;
                end
            end
            STREAM: begin
                handshake = rk_if.rk_ready;
                if (handshake && (cnt_reg == 5'd31)) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mk_reg         <= '0;
            mode_reg       <= 1'b0;
            cnt_reg        <= '0;
            done_reg       <= 1'b0;
            keys_valid_reg <= 1'b0;
            rd_key_reg     <= '0;
            for (int j = 0; j < 4; j++) begin
                k_reg[j] <= '0;
            end
        end else begin
            done_reg   <= (state_reg != IDLE) && (state_next == IDLE);
            rd_key_reg <= keys_valid_reg ? rf[rd_idx] : '0;
            if (accept) begin
                mk_reg         <= mk;
                mode_reg       <= mode;
                keys_valid_reg <= 1'b0;
            end
            if (expand_last) begin
                keys_valid_reg <= 1'b1;
            end
            case (state_reg)
                LOAD: begin
                    k_reg[0] <= mk_reg[127:96] ^ FK[127:96];
                    k_reg[1] <= mk_reg[95:64]  ^ FK[95:64];
                    k_reg[2] <= mk_reg[63:32]  ^ FK[63:32];
                    k_reg[3] <= mk_reg[31:0]   ^ FK[31:0];
                    cnt_reg  <= '0;
                end
                EXPAND: begin
                    k_reg[0] <= k_reg[1];
                    k_reg[1] <= k_reg[2];
                    k_reg[2] <= k_reg[3];
                    k_reg[3] <= rk_new;
                    cnt_reg  <= cnt_reg + 5'd1;
                end
                STREAM: begin
                    if (handshake) begin
                        cnt_reg <= cnt_reg + 5'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    generate
        for (genvar gi = 0; gi < 32; gi++) begin : g_rf
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    rf[gi] <= '0;
                end else if ((state_reg == EXPAND) && (cnt_reg == 5'(gi))) begin
                    rf[gi] <= rk_new;
                end
            end
        end
    endgenerate

    // Decrypt order walks the file backwards: 31 - cnt is cnt with every bit inverted.
    assign busy           = (state_reg != IDLE);
    assign done           = done_reg;
    assign keys_valid     = keys_valid_reg;
    assign rd_key         = rd_key_reg;
    assign rk_if.rk_valid = (state_reg == STREAM);
    assign rk_if.rk_last  = (state_reg == STREAM) && (cnt_reg == 5'd31);
    assign rk_if.rk_data  = (state_reg == STREAM) ? rf[cnt_reg ^ {5{mode_reg}}] : '0;

endmodule
